// File: rtl/mem_wb_pkg.sv
// Shared types and lane helpers for the cache-to-memory write buffer.
// Memory lanes are big-endian: lane 0 carries bits [31:24] of the word.
package mem_wb_pkg;

    typedef logic [31:0]      word_t;
    typedef logic [0:3][7:0]  lanes_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } wb_state_e;

    function automatic lanes_t pack_lanes(input word_t w);
        lanes_t l;
        for (int i = 0; i < 4; i++) begin
            l[i] = w[31-8*i -: 8];
        end
        return l;
    endfunction

    function automatic word_t unpack_lanes(input lanes_t l);
        word_t w;
        for (int i = 0; i < 4; i++) begin
            w[31-8*i -: 8] = l[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular {word address, data} FIFO with a combinational youngest-match
// search over the live entries, used to forward buffered writes to reads.
module wb_fifo
    import mem_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic [29:0] push_addr_i,
    input  word_t       push_data_i,
    input  logic        pop_i,
    input  logic [29:0] fwd_addr_i,
    output logic        full_o,
    output logic        empty_o,
    output logic [29:0] head_addr_o,
    output word_t       head_data_o,
    output logic        fwd_hit_o,
    output word_t       fwd_data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_w;
    logic [29:0]   addr_mem [DEPTH];
    word_t         data_mem [DEPTH];
    logic          do_push, do_pop;

    assign count_w = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr_q[AW-1:0]] <= push_addr_i;
            data_mem[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign head_addr_o = addr_mem[rd_ptr_q[AW-1:0]];
    assign head_data_o = data_mem[rd_ptr_q[AW-1:0]];

    // Entries are examined by age (0 = head); only live entries may match.
    logic [AW-1:0]    age_idx  [DEPTH];
    logic [DEPTH-1:0] age_match;
    word_t            age_data [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        assign age_idx[gi]   = rd_ptr_q[AW-1:0] + AW'(gi);
        assign age_match[gi] = ((AW+1)'(gi) < count_w) &&
                               (addr_mem[age_idx[gi]] == fwd_addr_i);
        assign age_data[gi]  = data_mem[age_idx[gi]];
    end

    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_match[i]) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = age_data[i];
            end
        end
    end

endmodule

// File: rtl/mem_write_buffer.sv
// Write buffer between data cache and memory: buffers write-throughs, drains
// them in the background, serves read misses and forwards buffered reads.
module mem_write_buffer
    import mem_wb_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int MEM_LATENCY = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   req_valid,
    input  logic   req_write,
    input  word_t  req_addr,
    input  word_t  req_wdata,
    output logic   req_ready,
    output logic   rsp_valid,
    output word_t  rsp_rdata,
    output word_t  mem_addr,
    output lanes_t mem_data_in,
    input  lanes_t mem_data_out,
    output logic   mem_write_en,
    output logic   idle
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    wb_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    word_t       mem_addr_q, mem_addr_d;
    lanes_t      mem_data_q, mem_data_d;
    logic        mem_we_q, mem_we_d;
    logic        rsp_valid_q, rsp_valid_d;
    word_t       rsp_rdata_q, rsp_rdata_d;
    logic        pend_valid_q, pend_valid_d;
    word_t       pend_data_q, pend_data_d;

    logic        full, empty, fwd_hit, last, push, pop;
    logic        fwd_take, miss_take, mem_rsp;
    logic [29:0] head_addr;
    word_t       head_data, fwd_data;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

    assign last      = (cnt_q == CW'(MEM_LATENCY - 1));
    assign push      = req_valid & req_write & ~full;
    assign pop       = (state_q == WRITE) & last;
    assign fwd_take  = req_valid & ~req_write & fwd_hit;
    assign miss_take = req_valid & ~req_write & ~fwd_hit & (state_q == IDLE);
    assign mem_rsp   = (state_q == READ) & last;
    assign req_ready = req_write ? ~full : (fwd_hit | (state_q == IDLE));

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_addr_i (req_addr[31:2]),
        .push_data_i (req_wdata),
        .pop_i       (pop),
        .fwd_addr_i  (req_addr[31:2]),
        .full_o      (full),
        .empty_o     (empty),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .fwd_hit_o   (fwd_hit),
        .fwd_data_o  (fwd_data)
    );

    // Memory-side registers are loaded on entry to an access so they stay
    // stable for the whole access; a read miss wins over draining.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (miss_take) begin
                    state_d    = READ;
                    mem_addr_d = {req_addr[31:2], 2'b00};
                end else if (!empty) begin
                    state_d    = WRITE;
                    mem_addr_d = {head_addr, 2'b00};
                    mem_data_d = pack_lanes(head_data);
                    mem_we_d   = 1'b1;
                end
            end
            READ, WRITE: begin
                mem_we_d = (state_q == WRITE) & ~last;
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A forward hit colliding with a memory read completion is held one cycle.
    always_comb begin
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        if (mem_rsp) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = unpack_lanes(mem_data_out);
            if (fwd_take) begin
                pend_valid_d = 1'b1;
                pend_data_d  = fwd_data;
            end
        end else if (pend_valid_q) begin
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = pend_data_q;
            pend_valid_d = fwd_take;
            if (fwd_take) pend_data_d = fwd_data;
        end else if (fwd_take) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = fwd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_in  = mem_data_q;
    assign mem_write_en = mem_we_q;
    assign idle         = empty & (state_q == IDLE) & ~pend_valid_q;

endmodule
